alu_seq_divider: RTL and testbench

//  Multi-cycle restoring integer divider. Consumes operand pairs over a valid/ready request

---
 rtl/alu_div_pkg.sv | 26 ++
 rtl/alu_div_step.sv | 29 ++
 rtl/alu_seq_divider.sv | 191 +++++++++++++++++++
 tb/tb_alu_seq_divider.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// Result fields are sized to DIV_W_MAX; the divider supports 4 <= N <= DIV_W_MAX.
package alu_div_pkg;

    localparam int unsigned DIV_W_MAX = 32;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

    typedef struct packed {
        logic [DIV_W_MAX-1:0] q;
        logic [DIV_W_MAX-1:0] r;
        logic                 zero;
        logic                 overflow;
        logic                 div_zero;
    } div_result_t;

    // Most negative two's-complement value of an n-bit word.
    function automatic logic [DIV_W_MAX-1:0] min_neg(input int unsigned n);
        return DIV_W_MAX'(1) << (n - 1);
    endfunction

endpackage

// File: rtl/alu_div_step.sv
// One restoring division step: shift {rem, quo} left by one and subtract the
// divisor from the partial remainder when it fits.
module alu_div_step #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] rem_i,
    input  logic [N-1:0] quo_i,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] rem_o,
    output logic [N-1:0] quo_o
);

    logic [N:0] shifted;
    logic [N:0] diff;

    // Trial subtract; the borrow bit (diff[N]) says the divisor did not fit.
    always_comb begin
        shifted = {rem_i, quo_i[N-1]};
        diff    = shifted - {1'b0, d_i};
        if (!diff[N]) begin
            rem_o = diff[N-1:0];
            quo_o = {quo_i[N-2:0], 1'b1};
        end else begin
            rem_o = shifted[N-1:0];
            quo_o = {quo_i[N-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/alu_seq_divider.sv
// Multi-cycle restoring integer divider with valid/ready request and response
// channels. One subtract-and-shift step per clock; the first DONE cycle applies
// the sign fix-up and registers the result, so Out_Valid rises N+1 edges after
// accept (1 edge for divide-by-zero and MIN / -1).
// Optional feature: define ALU_DIV_SIGNED_EN to honour the Signed input
// (magnitude negation, result sign fix-up and the MIN / -1 Overflow case).
module alu_seq_divider
    import alu_div_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic         CLK,
    input  logic         nReset,
    input  logic         In_Valid,
    output logic         In_Ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Signed,
    output logic         Out_Valid,
    input  logic         Out_Ready,
    output logic [N-1:0] Q,
    output logic [N-1:0] R,
    output logic         Zero,
    output logic         Overflow,
    output logic         DivZero
);

    localparam int unsigned CW = $clog2(N);
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

    div_state_t  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  rem_q, rem_d;
    logic [N-1:0]  quo_q, quo_d;
    logic [N-1:0]  dvs_q, dvs_d;
    logic          dz_q, dz_d;
    logic          ovf_q, ovf_d;
    logic          valid_q, valid_d;
    div_result_t   res_q, res_d;

    logic [N-1:0]  step_rem, step_quo;
    logic [N-1:0]  a_mag, b_mag;
    logic [N-1:0]  spec_q;
    logic [N-1:0]  q_fix, r_fix;
    logic          div_zero, ovf_case, special, in_fire;

    // Request accepted only in IDLE and never while reset is held.
    assign In_Ready = (state_q == IDLE) && nReset;
    assign in_fire  = In_Valid && In_Ready;
    assign div_zero = (B == '0);
    assign special  = div_zero || ovf_case;

`ifdef ALU_DIV_SIGNED_EN
    localparam logic [N-1:0] MIN_NEG = N'(min_neg(N));

    logic a_neg, b_neg;
    logic q_neg_q, q_neg_d, r_neg_q, r_neg_d;

    assign a_neg    = Signed && A[N-1];
    assign b_neg    = Signed && B[N-1];
    assign ovf_case = Signed && (A == MIN_NEG) && (&B);
    assign a_mag    = a_neg ? -A : A;
    assign b_mag    = b_neg ? -B : B;
    assign spec_q   = ovf_case ? MIN_NEG : '1;
    assign q_neg_d  = !special && (a_neg ^ b_neg);
    assign r_neg_d  = !special && a_neg;
    assign q_fix    = q_neg_q ? -quo_q : quo_q;
    assign r_fix    = r_neg_q ? -rem_q : rem_q;

    // Result signs captured at accept; special cases are already final.
    always_ff @(posedge CLK or negedge nReset) begin
        if (!nReset) begin
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else if (in_fire) begin
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
        end
    end
`else
    logic unused_signed;

    assign unused_signed = Signed;
    assign ovf_case      = 1'b0;
    assign a_mag         = A;
    assign b_mag         = B;
    assign spec_q        = '1;
    assign q_fix         = quo_q;
    assign r_fix         = rem_q;
`endif

    alu_div_step #(.N(N)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .d_i   (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    // Next-state logic: accept/preload, N steps, finalise, then hold until consumed.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;
        res_d   = res_q;
        unique case (state_q)
            IDLE: begin
                if (in_fire) begin
                    dz_d  = div_zero;
                    ovf_d = ovf_case;
                    if (special) begin
                        // Preload the final answer; the finalise cycle just registers it.
                        quo_d   = spec_q;
                        rem_d   = div_zero ? A : '0;
                        state_d = DONE;
                    end else begin
                        quo_d   = a_mag;
                        rem_d   = '0;
                        dvs_d   = b_mag;
                        cnt_d   = '0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!valid_q) begin
                    res_d.q        = DIV_W_MAX'(q_fix);
                    res_d.r        = DIV_W_MAX'(r_fix);
                    res_d.zero     = (q_fix == '0);
                    res_d.overflow = ovf_q;
                    res_d.div_zero = dz_q;
                    valid_d        = 1'b1;
                end else if (Out_Ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge CLK or negedge nReset) begin
        // NOTE: the datapath is reset along with control so a mid-operation reset
        // leaves no stale result visible on Q/R/flags.
        if (!nReset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            res_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            res_q   <= res_d;
        end
    end

    assign Out_Valid = valid_q;
    assign Q         = res_q.q[N-1:0];
    assign R         = res_q.r[N-1:0];
    assign Zero      = res_q.zero;
    assign Overflow  = res_q.overflow;
    assign DivZero   = res_q.div_zero;

endmodule

// File: tb/tb_alu_seq_divider.sv
// Self-checking bench for alu_seq_divider (N = 32). A behavioural model built on
// plain integer division predicts every response; a negedge monitor compares
// the DUT against it on every valid cycle, and directed transactions pin
// hand-computed values, latency and handshake behaviour.
module tb_alu_seq_divider;

`ifdef ALU_DIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        logic        o;
        logic        dz;
    } exp_t;

    logic        CLK;
    logic        nReset;
    logic        In_Valid;
    logic        In_Ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        Signed;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [31:0] Q;
    logic [31:0] R;
    logic        Zero;
    logic        Overflow;
    logic        DivZero;

    int n_checks = 0;
    int n_errors = 0;
    exp_t exp_q[$];
    logic prev_v = 1'b0;
    logic prev_r = 1'b0;

    alu_seq_divider #(.N(32)) dut (
        .CLK       (CLK),
        .nReset    (nReset),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .A         (A),
        .B         (B),
        .Signed    (Signed),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Q         (Q),
        .R         (R),
        .Zero      (Zero),
        .Overflow  (Overflow),
        .DivZero   (DivZero)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // Expected response straight from the arithmetic rules.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t   e;
        longint sa, sb, sq, sr;
        e = '0;
        if (b == 32'd0) begin
            e.q  = 32'hFFFF_FFFF;
            e.r  = a;
            e.dz = 1'b1;
        end else if (SIGNED_EN && s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000;
            e.r = 32'd0;
            e.o = 1'b1;
        end else if (SIGNED_EN && s) begin
            sa  = longint'($signed(a));
            sb  = longint'($signed(b));
            sq  = sa / sb;
            sr  = sa % sb;
            e.q = sq[31:0];
            e.r = sr[31:0];
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        e.z = (e.q == 32'd0);
        return e;
    endfunction

    // Monitor: reset values, model comparison on every valid cycle, handshake rules.
    always @(negedge CLK) begin
        if (!nReset) begin
            exp_q.delete();
            check("rst_in_ready", {63'd0, In_Ready}, 64'd0);
            check("rst_outputs", {Out_Valid, Q, R, Zero, Overflow, DivZero}, 64'd0);
            prev_v = 1'b0;
            prev_r = 1'b0;
        end else begin
            if (prev_v && !prev_r) check("mon_valid_held", {63'd0, Out_Valid}, 64'd1);
            if (prev_v && prev_r) check("mon_ready_after_consume", {62'd0, In_Ready, Out_Valid}, 64'd2);
            if (Out_Valid) begin
                check("mon_busy_in_ready", {63'd0, In_Ready}, 64'd0);
                if (exp_q.size() == 0) begin
                    check("mon_unexpected_valid", 64'd1, 64'd0);
                end else begin
                    check("mon_q", {32'd0, Q}, {32'd0, exp_q[0].q});
                    check("mon_r", {32'd0, R}, {32'd0, exp_q[0].r});
                    check("mon_flags", {61'd0, Zero, Overflow, DivZero},
                          {61'd0, exp_q[0].z, exp_q[0].o, exp_q[0].dz});
                    if (Out_Ready) void'(exp_q.pop_front());
                end
            end
            if (In_Valid && In_Ready) exp_q.push_back(model(A, B, Signed));
            prev_v = Out_Valid;
            prev_r = Out_Ready;
        end
    end

    // One complete transaction with literal expectations; hold = cycles of Out_Ready low.
    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input int hold, input logic [31:0] eq,
                       input logic [31:0] er, input logic [2:0] ef, input int lat);
        int n;
        A = a; B = b; Signed = s; In_Valid = 1'b1; Out_Ready = (hold == 0);
        n = 0;
        while (!In_Ready && n < 100) begin @(posedge CLK); #1; n++; end
        check({tag, "_accept"}, {63'd0, In_Ready}, 64'd1);
        @(posedge CLK); #1;
        In_Valid = 1'b0; A = ~a; B = ~b; Signed = ~s;
        n = 0;
        while (!Out_Valid && n < 100) begin @(posedge CLK); #1; n++; end
        check({tag, "_latency"}, 64'(n), 64'(lat));
        check({tag, "_q"}, {32'd0, Q}, {32'd0, eq});
        check({tag, "_r"}, {32'd0, R}, {32'd0, er});
        check({tag, "_flags"}, {61'd0, Zero, Overflow, DivZero}, {61'd0, ef});
        if (hold > 0) begin
            repeat (hold) @(posedge CLK);
            #1;
            check({tag, "_hold_valid"}, {62'd0, Out_Valid, In_Ready}, 64'd2);
            check({tag, "_hold_q"}, {Q, R}, {eq, er});
            Out_Ready = 1'b1;
        end
        @(posedge CLK); #1;
        check({tag, "_release"}, {62'd0, Out_Valid, In_Ready}, 64'd1);
        Out_Ready = 1'b0;
    endtask

    initial begin
        int n;
        nReset = 1'b0; In_Valid = 1'b0; A = '0; B = '0; Signed = 1'b0; Out_Ready = 1'b0;
        #1;
        check("rst_t0_in_ready", {63'd0, In_Ready}, 64'd0);
        check("rst_t0_outputs", {Out_Valid, Q, R, Zero, Overflow, DivZero}, 64'd0);
        repeat (3) @(posedge CLK);
        #1 nReset = 1'b1;
        #1 check("rst_release_ready", {63'd0, In_Ready}, 64'd1);

        // Unsigned basics, held Out_Ready
        run("u100_7",  32'd100, 32'd7, 1'b0, 0, 32'd14, 32'd2, 3'b000, 33);
        run("u5_9",    32'd5,   32'd9, 1'b0, 0, 32'd0,  32'd5, 3'b100, 33);
        run("umax_1",  32'hFFFF_FFFF, 32'd1, 1'b0, 0, 32'hFFFF_FFFF, 32'd0, 3'b000, 33);
        run("u0_5",    32'd0, 32'd5, 1'b0, 0, 32'd0, 32'd0, 3'b100, 33);
        run("umax_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 32'd1, 32'd0, 3'b000, 33);
        run("u_big",   32'hDEAD_BEEF, 32'h0001_0000, 1'b0, 0, 32'h0000_DEAD, 32'h0000_BEEF, 3'b000, 33);
        // Divide by zero
        run("dz1234",  32'd1234, 32'd0, 1'b0, 0, 32'hFFFF_FFFF, 32'd1234, 3'b001, 1);
        run("dz_s",    32'hFFFF_FFF9, 32'd0, 1'b1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 3'b001, 1);

`ifdef ALU_DIV_SIGNED_EN
        run("s_m7_2",  32'hFFFF_FFF9, 32'd2, 1'b1, 0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 3'b000, 33);
        run("s_7_m2",  32'd7, 32'hFFFF_FFFE, 1'b1, 0, 32'hFFFF_FFFD, 32'd1, 3'b000, 33);
        run("s_m8_m3", 32'hFFFF_FFF8, 32'hFFFF_FFFD, 1'b1, 0, 32'd2, 32'hFFFF_FFFE, 3'b000, 33);
        run("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 32'h8000_0000, 32'd0, 3'b010, 1);
        run("s_min_1", 32'h8000_0000, 32'd1, 1'b1, 0, 32'h8000_0000, 32'd0, 3'b000, 33);
        run("s_bp",    32'hFFFF_FF9C, 32'd7, 1'b1, 10, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 3'b000, 33);
`else
        run("ns_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 0, 32'h7FFF_FFFC, 32'd1, 3'b000, 33);
        run("ns_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 32'd0, 32'h8000_0000, 3'b100, 33);
`endif
        // Backpressure
        run("bp1000_10", 32'd1000, 32'd10, 1'b0, 10, 32'd100, 32'd0, 3'b000, 33);

        // Reset pulse in the middle of CALC: response is lost
        A = 32'd1000; B = 32'd3; Signed = 1'b0; In_Valid = 1'b1; Out_Ready = 1'b1;
        n = 0;
        while (!In_Ready && n < 100) begin @(posedge CLK); #1; n++; end
        check("abort_accept", {63'd0, In_Ready}, 64'd1);
        @(posedge CLK); #1;
        In_Valid = 1'b0;
        repeat (15) @(posedge CLK);
        #1 nReset = 1'b0;
        #1;
        check("abort_in_ready", {63'd0, In_Ready}, 64'd0);
        check("abort_outputs", {Out_Valid, Q, R, Zero, Overflow, DivZero}, 64'd0);
        @(posedge CLK); #1;
        nReset = 1'b1;
        #1 check("abort_release_ready", {63'd0, In_Ready}, 64'd1);
        repeat (40) @(posedge CLK);
        #1 check("abort_no_response", {63'd0, Out_Valid}, 64'd0);
        run("after_abort", 32'd1000, 32'd3, 1'b0, 0, 32'd333, 32'd1, 3'b000, 33);

        repeat (3) @(posedge CLK);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
